// File: rtl/ray_aabb_pkg.sv
// ray_aabb_pkg: shared widths, latency and result type for the ray/box issue controller
package ray_aabb_pkg;
    localparam int FP_W  = 23;
    localparam int LAT   = 38;
    localparam int TAG_W = 8;
    localparam int PTS_W = 9 * FP_W;
    localparam int DIV_W = 3 * FP_W;

    typedef struct packed {
        logic             hit;
        logic [TAG_W-1:0] tag;
    } res_t;
endpackage

// File: rtl/ray_aabb_res_fifo.sv
// ray_aabb_res_fifo: synchronous first-word-fall-through result FIFO with occupancy count
module ray_aabb_res_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;

    // head is zero while empty so the outputs read 0 after reset
    assign rd_data = (count == '0) ? '0 : mem[rp];

    // storage write, no reset needed since reads are gated by count
    always_ff @(posedge clk)
        if (wr_en) mem[wp] <= wr_data;

    // pointers and occupancy
    always_ff @(posedge clk)
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(wr_en);
            rp    <= rp + AW'(rd_en);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
endmodule

// File: rtl/ray_aabb_sched.sv
// ray_aabb_sched: credit-based issue and in-order result collection for the ray/box datapath
module ray_aabb_sched #(
    parameter int FP_W  = ray_aabb_pkg::FP_W,
    parameter int LAT   = ray_aabb_pkg::LAT,
    parameter int DEPTH = 64,
    parameter int TAG_W = ray_aabb_pkg::TAG_W,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [9*FP_W-1:0]   in_pts,
    input  logic [2:0]          in_dir,
    input  logic [3*FP_W-1:0]   in_div,
    input  logic [TAG_W-1:0]    in_tag,
    output logic [9*FP_W-1:0]   dp_pts,
    output logic [2:0]          dp_dir,
    output logic [3*FP_W-1:0]   dp_div,
    input  logic                dp_hit,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_hit,
    output logic [TAG_W-1:0]    out_tag,
    input  logic                stat_clr,
    output logic [CNT_W-1:0]    stat_jobs,
    output logic [CNT_W-1:0]    stat_hits,
    output logic                idle
);
    import ray_aabb_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]    credit, credit_nxt, count;
    logic [LAT-1:0]   vld;
    logic [TAG_W-1:0] tags [LAT];
    logic             accept, pop, wr;

    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign wr        = vld[LAT-1];
    assign out_valid = count != '0;
    assign idle      = credit == CW'(DEPTH);

    // free result slots after this edge's accept and pop
    always_comb credit_nxt = credit - CW'(accept) + CW'(pop);

    // credit counter with in_ready registered from the next credit value
    always_ff @(posedge clk)
        if (!rst_n) begin
            credit   <= CW'(DEPTH);
            in_ready <= 1'b1;
        end else begin
            credit   <= credit_nxt;
            in_ready <= credit_nxt != '0;
        end

    // operand registers feeding the datapath, loaded only on accept
    always_ff @(posedge clk)
        if (!rst_n) begin
            dp_pts <= '0;
            dp_dir <= '0;
            dp_div <= '0;
        end else if (accept) begin
            dp_pts <= in_pts;
            dp_dir <= in_dir;
            dp_div <= in_div;
        end

    // valid bits track jobs through the datapath; clearing them discards in-flight work
    always_ff @(posedge clk)
        if (!rst_n) vld <= '0;
        else vld <= {vld[LAT-2:0], accept};

    // tags ride alongside the valid bits
    always_ff @(posedge clk) begin
        tags[0] <= in_tag;
        for (int i = 1; i < LAT; i++) tags[i] <= tags[i-1];
    end

    // saturating statistics, clear wins over increment
    always_ff @(posedge clk)
        if (!rst_n || stat_clr) begin
            stat_jobs <= '0;
            stat_hits <= '0;
        end else begin
            if (accept && !(&stat_jobs)) stat_jobs <= stat_jobs + CNT_W'(1);
            if (wr && dp_hit && !(&stat_hits)) stat_hits <= stat_hits + CNT_W'(1);
        end

    ray_aabb_res_fifo #(.W(TAG_W + 1), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr),
        .wr_data ({dp_hit, tags[LAT-1]}),
        .rd_en   (pop),
        .rd_data ({out_hit, out_tag}),
        .count   (count)
    );
endmodule

// File: tb/tb_ray_aabb_sched.sv
// tb_ray_aabb_sched: directed and randomized checks of issue, credit flow, ordering and statistics
module tb_ray_aabb_sched;
    import ray_aabb_pkg::*;

    localparam int D = 64;

    logic clk, rst_n;
    logic in_valid, in_ready, dp_hit, out_valid, out_ready, out_hit, stat_clr, idle;
    logic [PTS_W-1:0] in_pts, dp_pts;
    logic [2:0] in_dir, dp_dir;
    logic [DIV_W-1:0] in_div, dp_div;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [31:0] stat_jobs, stat_hits;

    logic s_in_valid, s_in_ready, s_dp_hit, s_out_valid, s_out_ready, s_out_hit, s_stat_clr, s_idle;
    logic [PTS_W-1:0] s_in_pts, s_dp_pts;
    logic [2:0] s_dp_dir;
    logic [DIV_W-1:0] s_dp_div;
    logic [TAG_W-1:0] s_in_tag, s_out_tag;
    logic [3:0] s_stat_jobs, s_stat_hits;

    int checks = 0, errors = 0;
    int outstanding = 0, pops = 0, first_pop = 0, last_pop = 0, cyc = 0;
    logic [TAG_W:0] sb [$];

    ray_aabb_sched dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pts(in_pts), .in_dir(in_dir), .in_div(in_div), .in_tag(in_tag),
        .dp_pts(dp_pts), .dp_dir(dp_dir), .dp_div(dp_div), .dp_hit(dp_hit),
        .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit), .out_tag(out_tag),
        .stat_clr(stat_clr), .stat_jobs(stat_jobs), .stat_hits(stat_hits), .idle(idle)
    );

    ray_aabb_sched #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_pts(s_in_pts), .in_dir(3'b0), .in_div('0), .in_tag(s_in_tag),
        .dp_pts(s_dp_pts), .dp_dir(s_dp_dir), .dp_div(s_dp_div), .dp_hit(s_dp_hit),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_hit(s_out_hit), .out_tag(s_out_tag),
        .stat_clr(s_stat_clr), .stat_jobs(s_stat_jobs), .stat_hits(s_stat_hits), .idle(s_idle)
    );

    // behavioural datapath: the operand register plus LAT-1 stages gives LAT edges of latency
    logic hq [LAT-1];
    logic sq [LAT-1];
    assign dp_hit   = hq[LAT-2];
    assign s_dp_hit = sq[LAT-2];
    always @(posedge clk) begin
        hq[0] <= ^dp_pts[FP_W-1:0];
        sq[0] <= ^s_dp_pts[FP_W-1:0];
        for (int i = 1; i < LAT-1; i++) begin
            hq[i] <= hq[i-1];
            sq[i] <= sq[i-1];
        end
    end

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string t, input logic [255:0] o, input logic [255:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", t, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PTS_W-1:0] rnd_pts();
        logic [223:0] t = '0;
        for (int k = 0; k < 7; k++) t = {t[191:0], 32'($urandom)};
        return t[PTS_W-1:0];
    endfunction

    task automatic wait_idle(input int lim);
        int n = 0;
        while (!idle && n < lim) begin
            step();
            n++;
        end
        chk("idle_wait", idle, 1'b1);
    endtask

    // scoreboard: jobs outstanding in order; handshakes observed mid-cycle take effect at the next edge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                sb.delete();
                outstanding = 0;
            end else begin
                chk("in_ready_m", in_ready, outstanding != D);
                chk("idle_m", idle, outstanding == 0);
                if (out_valid && out_ready) begin
                    chk("pop_nonempty", sb.size() != 0, 1'b1);
                    if (sb.size() != 0) begin
                        chk("result", {out_hit, out_tag}, sb[0]);
                        sb.pop_front();
                        outstanding--;
                    end
                    pops++;
                    if (pops == 1) first_pop = cyc;
                    last_pop = cyc;
                end
                if (in_valid && in_ready) begin
                    sb.push_back({^in_pts[FP_W-1:0], in_tag});
                    outstanding++;
                end
            end
        end
    end

    initial begin
        int n, acc, hits, stall, bad;
        logic exp_hit;
        rst_n = 0; in_valid = 0; out_ready = 0; stat_clr = 0;
        in_pts = '0; in_dir = '0; in_div = '0; in_tag = '0;
        s_in_valid = 0; s_out_ready = 0; s_stat_clr = 0; s_in_pts = '0; s_in_tag = '0;
        repeat (3) step();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_hit", out_hit, 1'b0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_dp_pts", dp_pts, 0);
        chk("rst_dp_dir", dp_dir, 0);
        chk("rst_dp_div", dp_div, 0);
        chk("rst_stat_jobs", stat_jobs, 0);
        chk("rst_stat_hits", stat_hits, 0);
        chk("rst_idle", idle, 1'b1);
        rst_n = 1;
        repeat (6) step();

        // single job: latency and result
        in_valid = 1; in_pts = rnd_pts(); in_dir = 3'b101; in_div = {3{23'h12345}}; in_tag = 8'h5A;
        exp_hit = ^in_pts[FP_W-1:0];
        step();
        in_valid = 0;
        chk("dp_pts_load", dp_pts, in_pts);
        chk("dp_dir_load", dp_dir, 3'b101);
        n = 0;
        while (!out_valid && n < 200) begin
            step();
            n++;
        end
        chk("latency", n, LAT);
        chk("single_tag", out_tag, 8'h5A);
        chk("single_hit", out_hit, exp_hit);
        out_ready = 1;
        step();
        out_ready = 0;
        chk("single_idle", idle, 1'b1);
        chk("single_empty", out_valid, 1'b0);
        chk("single_jobs", stat_jobs, 1);

        // streaming 200 jobs back to back
        stat_clr = 1;
        step();
        stat_clr = 0;
        chk("clr_jobs", stat_jobs, 0);
        pops = 0; hits = 0; stall = 0; out_ready = 1;
        for (int i = 0; i < 200; i++) begin
            in_valid = 1; in_pts = rnd_pts(); in_tag = 8'(i);
            hits += int'(^in_pts[FP_W-1:0]);
            if (!in_ready) stall++;
            step();
        end
        in_valid = 0;
        wait_idle(500);
        chk("stream_stall", stall, 0);
        chk("stream_pops", pops, 200);
        chk("stream_rate", last_pop - first_pop, 199);
        chk("stream_jobs", stat_jobs, 200);
        chk("stream_hits", stat_hits, hits);

        // full stall: exactly DEPTH accepts
        out_ready = 0; in_valid = 1; acc = 0;
        repeat (100) begin
            in_pts = rnd_pts(); in_tag = 8'($urandom);
            if (in_ready) acc++;
            step();
        end
        chk("stall_accepts", acc, D);
        chk("stall_ready", in_ready, 1'b0);
        repeat (LAT + 2) step();
        chk("stall_ready2", in_ready, 1'b0);
        chk("stall_valid", out_valid, 1'b1);

        // credit edge: a pop at zero credit re-enables one accept next cycle
        out_ready = 1;
        step();
        out_ready = 0;
        chk("credit_reopen", in_ready, 1'b1);
        step();
        chk("credit_closed", in_ready, 1'b0);
        in_valid = 0;
        pops = 0; out_ready = 1;
        wait_idle(500);
        chk("drain_pops", pops, D);

        // reset with 20 jobs in flight
        for (int i = 0; i < 20; i++) begin
            in_valid = 1; in_pts = rnd_pts(); in_tag = 8'(i + 100);
            step();
        end
        in_valid = 0;
        rst_n = 0;
        step();
        rst_n = 1;
        bad = 0;
        repeat (LAT + 5) begin
            if (out_valid !== 1'b0) bad = 1;
            step();
        end
        chk("flush_valid", bad, 0);
        chk("flush_idle", idle, 1'b1);
        chk("flush_ready", in_ready, 1'b1);
        chk("flush_jobs", stat_jobs, 0);
        chk("flush_hits", stat_hits, 0);
        out_ready = 0;

        // saturation on the narrow-counter instance
        s_out_ready = 1;
        for (int i = 0; i < 20; i++) begin
            s_in_valid = 1; s_in_pts = {rnd_pts() >> FP_W, 23'h1}; s_in_tag = 8'(i);
            step();
        end
        s_in_valid = 0;
        n = 0;
        while (!s_idle && n < 200) begin
            step();
            n++;
        end
        chk("sat_idle", s_idle, 1'b1);
        chk("sat_jobs", s_stat_jobs, 4'hF);
        chk("sat_hits", s_stat_hits, 4'hF);
        s_stat_clr = 1; s_in_valid = 1;
        step();
        s_stat_clr = 0; s_in_valid = 0;
        chk("sat_clr_jobs", s_stat_jobs, 0);
        chk("sat_clr_hits", s_stat_hits, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ray_aabb_sched.md
# ray_aabb_sched

Issue controller and result collector for the fully pipelined `Ray_AABB_11_9` ray/box intersection datapath. It accepts ray/box jobs from an upstream producer through a valid/ready handshake and drives them into the datapath at up to one job per cycle. It tracks each job's tag through the fixed pipeline latency, captures `hit_miss` at the correct cycle, and returns in-order results through a second valid/ready handshake. Credit-based issue guarantees that no result is lost, because the datapath itself cannot stall.

## Interface
Parameters:
- `FP_W`, 23: operand width (11-bit exponent / 9-bit fraction custom float plus flags).
- `LAT`, 38: datapath latency in clock edges; must match the instantiated datapath.
- `DEPTH`, 64: result FIFO depth; power of two; `DEPTH >= LAT`.
- `TAG_W`, 8: job tag width.
- `CNT_W`, 32: statistics counter width.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `in_valid`, in, 1: job offered.
- `in_ready`, out, 1: job accepted when `in_valid & in_ready`.
- `in_pts`, in, `9*FP_W`: x0,y0,z0,x1,y1,z1,x2,y2,z2, with x0 in the MSBs.
- `in_dir`, in, 3: direction sign bits {x,y,z}.
- `in_div`, in, `3*FP_W`: reciprocal directions {divx,divy,divz}.
- `in_tag`, in, `TAG_W`: opaque job ID.
- `dp_pts`, out, `9*FP_W`: registered copy of `in_pts` to the datapath.
- `dp_dir`, out, 3: registered copy of `in_dir` to the datapath.
- `dp_div`, out, `3*FP_W`: registered copy of `in_div` to the datapath.
- `dp_hit`, in, 1: datapath `hit_miss`.
- `out_valid`, out, 1: result available.
- `out_ready`, in, 1: result consumed when `out_valid & out_ready`.
- `out_hit`, out, 1: intersection result.
- `out_tag`, out, `TAG_W`: tag of the job that produced the result.
- `stat_clr`, in, 1: synchronous clear of the statistics counters.
- `stat_jobs`, out, `CNT_W`: saturating count of accepted jobs.
- `stat_hits`, out, `CNT_W`: saturating count of results with `out_hit=1`, counted at FIFO write.
- `idle`, out, 1: no job in flight and the FIFO is empty.

## Operation
Credits:
- `credit` counts free result slots. It resets to `DEPTH`.
- `in_ready = (credit != 0)`. `in_ready` is driven directly from a register, with no combinational path from `out_ready`.
- On accept, `credit` decrements by 1. On pop, it increments by 1. When accept and pop occur in the same cycle, `credit` is unchanged.
- Invariant: `credit + in_flight + fifo_count == DEPTH`. The FIFO therefore can never overflow.

Issue:
- On accept, `dp_*` load the `in_*` operands.
- When there is no accept, `dp_*` hold their previous values. The datapath output for these cycles is ignored.

Tracking:
- A `LAT`-stage shift register carries {valid, tag}.
- Stage 0 loads {accept, `in_tag`}. Every stage shifts every cycle.
- When the tail stage is valid, {`dp_hit`, tag} is written to the FIFO on that edge.

Output:
- `out_*` present the FIFO head. `out_valid = !fifo_empty`.
- Results are returned in issue order.

Statistics:
- `stat_jobs` and `stat_hits` stop incrementing at all-ones.
- `stat_clr` has priority over an increment in the same cycle.

Idle:
- `idle = (credit == DEPTH)`.

## Timing
Reset (`rst_n=0` at an edge):
- `in_ready=1`, `out_valid=0`, `out_hit=0`, `out_tag=0`.
- `dp_*=0`, all shift-register valids 0, FIFO empty, `credit=DEPTH`.
- `stat_jobs=0`, `stat_hits=0`, `idle=1`.

Reset while jobs are in flight:
- All in-flight jobs and queued results are discarded.
- Residual datapath pipeline contents are never written to the FIFO, because all tracking valids are cleared.

Latency and throughput:
- A job accepted at edge E has its result written at edge E+LAT.
- `out_valid` is seen high in the cycle after E+LAT, so minimum accept-to-result latency is LAT+1 cycles.
- Sustained throughput is 1 job per cycle when `out_ready=1`.
- The result FIFO is first-word-fall-through. Simultaneous write and read on an empty FIFO is allowed: the entry appears on the next cycle.

Backpressure:
- With `out_ready=0`, exactly `DEPTH` jobs are accepted, then `in_ready=0`.
- One pop re-enables exactly one accept, in the cycle after the pop.

## Structure
- Package `ray_aabb_pkg` holds `FP_W`, `LAT`, derived widths `PTS_W=9*FP_W` and `DIV_W=3*FP_W`, and the packed result type {hit, tag}.
- One sub-module, `ray_aabb_res_fifo`: synchronous FWFT FIFO, width `TAG_W+1`, depth `DEPTH`, with count output.
- The credit counter, tag shift register and statistics counters live in the top level.

## Test plan
The bench uses a behavioural datapath model: a `LAT`-deep delay line with `hit = ^dp_pts[FP_W-1:0]`.
- **Single job:** tag 0x5A accepted at cycle 10 → `out_valid` rises at cycle 10+LAT+1=49 with `out_tag=0x5A` and the correct `out_hit`; `idle` returns to 1 after the pop.
- **Streaming:** 200 back-to-back jobs with tags 0..199 and `out_ready=1` → `in_ready` stays 1, results arrive in order, one per cycle, `stat_jobs=200`, and `stat_hits` matches the model.
- **Full stall:** `out_ready=0` with `in_valid=1` continuously → exactly 64 accepts, then `in_ready=0`; no FIFO overflow; releasing `out_ready` drains 64 results in order.
- **Credit edge:** at `credit=0`, assert pop and `in_valid` in the same cycle → one accept occurs the following cycle; `credit + in_flight + fifo_count == 64` is asserted every cycle.
- **Mid-flight reset:** pull `rst_n` low for 1 cycle with 20 jobs in flight → `out_valid` stays 0 for the next LAT+5 cycles, `idle=1`, and counters read 0.
- **Saturation:** with `CNT_W=4`, issue 20 hitting jobs → `stat_jobs=stat_hits=15`; `stat_clr` held together with an accept → `stat_jobs=0`.
